// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// The slave modport is the arbiter. The master modport is the requesters plus the memory.
interface mem_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 2
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          init_done;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_rd_data,
    output gnt0, gnt1, rvalid0, rvalid1,
    output rdata0, rdata1, init_done,
    output mem_rd_en, mem_wr_en,
    output mem_rd_addr, mem_wr_addr,
    output mem_wr_data
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_rd_data,
    input  gnt0, gnt1, rvalid0, rvalid1,
    input  rdata0, rdata1, init_done,
    input  mem_rd_en, mem_wr_en,
    input  mem_rd_addr, mem_wr_addr,
    input  mem_wr_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of mem_mod.
// It clears every memory word after reset and steers read data back to the requester that issued the read.
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_ADDR   = 4,
  parameter int ADDR_WIDTH = $clog2(MAX_ADDR)
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic {INIT, ARB} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(MAX_ADDR - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ptr_q, ptr_d;
  logic                  pend_q, pend_d;
  logic                  own_q, own_d;

  logic in_init, in_arb;
  logic g0, g1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      pend_q  <= 1'b0;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      own_q   <= own_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: if (cnt_q == LAST) state_d = ARB;
      ARB:  state_d = ARB;
      default: state_d = INIT;
    endcase
  end

  // Everything facing the memory or the requesters is forced quiet while rst is high.
  assign in_init = !rst && (state_q == INIT);
  assign in_arb  = !rst && (state_q == ARB);

  // Contention goes to the requester the pointer selects.
  assign g0 = in_arb && bus.req0 && (!bus.req1 || !ptr_q);
  assign g1 = in_arb && bus.req1 && (!bus.req0 || ptr_q);

  always_comb begin
    cnt_d  = in_init ? cnt_q + 1'b1 : cnt_q;
    ptr_d  = ptr_q;
    if (g0) ptr_d = 1'b1;
    if (g1) ptr_d = 1'b0;
    pend_d = (g0 && !bus.we0) || (g1 && !bus.we1);
    own_d  = g1;
  end

  always_comb begin
    bus.gnt0        = g0;
    bus.gnt1        = g1;
    bus.rvalid0     = !rst && pend_q && !own_q;
    bus.rvalid1     = !rst && pend_q && own_q;
    bus.rdata0      = bus.mem_rd_data;
    bus.rdata1      = bus.mem_rd_data;
    bus.init_done   = in_arb;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    unique case (1'b1)
      in_init: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = cnt_q;
      end
      g0: begin
        bus.mem_wr_en   = bus.we0;
        bus.mem_rd_en   = !bus.we0;
        bus.mem_wr_addr = bus.addr0;
        bus.mem_rd_addr = bus.addr0;
        bus.mem_wr_data = bus.wdata0;
      end
      g1: begin
        bus.mem_wr_en   = bus.we1;
        bus.mem_rd_en   = !bus.we1;
        bus.mem_wr_addr = bus.addr1;
        bus.mem_rd_addr = bus.addr1;
        bus.mem_wr_data = bus.wdata1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural mem_mod model.
// Covers init, round-robin, read return and reset while a read is in flight.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] mem [4];

  mem_arbiter_if #(.DW(8), .AW(2)) bus ();

  mem_arbiter #(
    .DATA_WIDTH(8),
    .MAX_ADDR(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0 = 0; bus.req1 = 0;
    bus.we0 = 0; bus.we1 = 0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'hA5;
    bus.mem_rd_data = 8'hEE;
    idle();
    bus.addr0 = 0; bus.addr1 = 0;
    bus.wdata0 = 0; bus.wdata1 = 0;
    tick(); tick();
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_done", bus.init_done, 0);
    chk("rst_wr", bus.mem_wr_en, 0);
    chk("rst_rd", bus.mem_rd_en, 0);
    chk("rst_rv0", bus.rvalid0, 0);

    rst = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("init_wr", bus.mem_wr_en, 1);
      chk("init_wa", bus.mem_wr_addr, i);
      chk("init_wd", bus.mem_wr_data, 0);
      chk("init_g", {bus.gnt0, bus.gnt1}, 0);
      chk("init_dn", bus.init_done, 0);
      tick();
    end
    chk("done", bus.init_done, 1);
    chk("idle_wr", bus.mem_wr_en, 0);

    // req0 writes addr1=56 then reads it back
    bus.req0 = 1; bus.we0 = 1;
    bus.addr0 = 1; bus.wdata0 = 56;
    #1;
    chk("w_gnt0", bus.gnt0, 1);
    chk("w_wr", bus.mem_wr_en, 1);
    chk("w_wa", bus.mem_wr_addr, 1);
    chk("w_wd", bus.mem_wr_data, 56);
    tick();
    bus.we0 = 0;
    #1;
    chk("r_gnt0", bus.gnt0, 1);
    chk("r_rd", bus.mem_rd_en, 1);
    chk("r_ra", bus.mem_rd_addr, 1);
    chk("r_wr", bus.mem_wr_en, 0);
    tick();
    bus.req0 = 0;
    bus.req1 = 1; bus.we1 = 1;
    bus.addr1 = 0; bus.wdata1 = 9;
    #1;
    chk("r_rv0", bus.rvalid0, 1);
    chk("r_rd0", bus.rdata0, 56);
    chk("r_rv1", bus.rvalid1, 0);
    chk("p_gnt1", bus.gnt1, 1);
    tick();

    // both requesters write continuously
    bus.req0 = 1; bus.we0 = 1;
    bus.addr0 = 0; bus.wdata0 = 8'h11;
    bus.req1 = 1; bus.we1 = 1;
    bus.addr1 = 2; bus.wdata1 = 8'h22;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_g0", bus.gnt0, (k % 2) == 0);
      chk("rr_g1", bus.gnt1, (k % 2) == 1);
      chk("rr_wr", bus.mem_wr_en, 1);
      chk("rr_rd", bus.mem_rd_en, 0);
      chk("rr_wd", bus.mem_wr_data, (k % 2) ? 8'h22 : 8'h11);
      tick();
    end

    // req1 writes addr3=200, req0 reads addr3 next cycle
    idle();
    bus.req1 = 1; bus.we1 = 1;
    bus.addr1 = 3; bus.wdata1 = 200;
    #1;
    chk("x_gnt1", bus.gnt1, 1);
    tick();
    idle();
    bus.req0 = 1; bus.addr0 = 3;
    #1;
    chk("x_gnt0", bus.gnt0, 1);
    chk("x_rd", bus.mem_rd_en, 1);
    tick();
    idle();
    #1;
    chk("x_rv0", bus.rvalid0, 1);
    chk("x_rd0", bus.rdata0, 200);
    chk("x_rv1", bus.rvalid1, 0);

    // write addr2=74, read addr2, then reset while the read is in flight
    bus.req0 = 1; bus.we0 = 1;
    bus.addr0 = 2; bus.wdata0 = 74;
    #1;
    chk("m_gw", bus.gnt0, 1);
    tick();
    bus.we0 = 0;
    #1;
    chk("m_gr", bus.gnt0, 1);
    tick();
    rst = 1;
    idle();
    bus.req1 = 1; bus.addr1 = 2;
    #1;
    chk("m_rv0", bus.rvalid0, 0);
    chk("m_rv1", bus.rvalid1, 0);
    chk("m_wr", bus.mem_wr_en, 0);
    chk("m_g1", bus.gnt1, 0);
    tick();
    rst = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("ri_g1", bus.gnt1, 0);
      chk("ri_wa", bus.mem_wr_addr, i);
      chk("ri_rv", {bus.rvalid0, bus.rvalid1}, 0);
      chk("ri_rd", bus.mem_rd_en, 0);
      tick();
    end
    chk("ri_dn", bus.init_done, 1);
    chk("ri_g1a", bus.gnt1, 1);
    chk("ri_ra", bus.mem_rd_addr, 2);
    tick();
    idle();
    #1;
    chk("ri_rv1", bus.rvalid1, 1);
    chk("ri_rd1", bus.rdata1, 0);
    chk("ri_rv0", bus.rvalid0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter and initialiser for the `mem_mod` single-clock memory. On reset it clears every word of the memory to zero, then shares the memory's read and write ports between requester 0 and requester 1, one access per cycle. It returns read data to the requester that issued the read. It sits directly in front of `mem_mod`; requesters never drive `mem_mod` themselves.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: word width.
- `MAX_ADDR`, default 4: number of memory words.
- `ADDR_WIDTH`, default `$clog2(MAX_ADDR)`: address width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  clock, all logic on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req0`, `req1`  input  1  access request; held until granted.
- `we0`, `we1`  input  1  request type: 1 = write, 0 = read.
- `addr0`, `addr1`  input  ADDR_WIDTH  access address.
- `wdata0`, `wdata1`  input  DATA_WIDTH  write data.
- `gnt0`, `gnt1`  output  1  combinational grant; the access is taken this cycle.
- `rvalid0`, `rvalid1`  output  1  read data valid for that requester.
- `rdata0`, `rdata1`  output  DATA_WIDTH  read data, wired to `mem_rd_data`.
- `init_done`  output  1  high once the clear sequence is complete.
- `mem_rd_en`, `mem_wr_en`  output  1  to `mem_mod`.
- `mem_rd_addr`, `mem_wr_addr`  output  ADDR_WIDTH  to `mem_mod`.
- `mem_wr_data`  output  DATA_WIDTH  to `mem_mod`.
- `mem_rd_data`  input  DATA_WIDTH  from `mem_mod`.

## Operation

- `mem_mod` contract:
  - Write when `mem_wr_en` is high at a rising edge.
  - `mem_rd_data` is valid one cycle after a cycle with `mem_rd_en` high.
- States: INIT and ARB.
  - Reset enters INIT with clear counter = 0 and priority pointer = 0.
- INIT:
  - `mem_wr_en` = 1, `mem_wr_addr` = counter, `mem_wr_data` = 0.
  - Counter increments every cycle.
  - On the cycle with counter = MAX_ADDR-1, the next state is ARB.
  - `gnt0`, `gnt1` and `mem_rd_en` stay 0; requests are ignored but stay pending.
- ARB:
  - Only `req0` high: grant 0. Only `req1` high: grant 1.
  - Both high: grant the requester the pointer selects.
  - After any grant, the pointer moves to the requester that was not granted. It does not change if no grant occurs.
  - Granted write: `mem_wr_en` = 1 with that requester's address and data.
  - Granted read: `mem_rd_en` = 1 with that requester's address. A one-bit owner tag is registered.
  - At most one of `mem_rd_en`/`mem_wr_en` is high per cycle. No grant means both are 0.
- Read return:
  - `rvalid<owner>` pulses one cycle after a granted read.
  - The other `rvalid` stays 0.
- Write then read of the same address in consecutive cycles returns the new data.
- Memory outputs are driven 0 while `rst` is high.

## Timing

- Reset values:
  - `gnt0`, `gnt1`, `rvalid0`, `rvalid1`, `init_done`, `mem_rd_en` = 0.
  - `mem_wr_en` = 0 while `rst` is high.
  - Pointer = 0.
- Init phase:
  - Lasts exactly MAX_ADDR cycles after `rst` falls.
  - `init_done` rises on the first ARB cycle and stays high until the next reset.
- Grant latency: 0 cycles. `gnt` is combinational from `req` in ARB.
- Read latency: 1 cycle from grant to `rvalid`.
- Back-to-back grants are allowed every cycle. A pending requester waits at most 1 cycle.
- Reset mid-operation:
  - A read in flight never raises `rvalid`.
  - The clear sequence restarts from address 0.
  - The pointer returns to 0.

## Test plan

- Release `rst`, no requests:
  - `mem_wr_en` high for 4 cycles with addresses 0,1,2,3 and data 0.
  - `init_done` rises on the 5th cycle.
  - `gnt0` and `gnt1` stay 0 throughout.
- After init, `req0` writes addr 1 data 56, then `req0` reads addr 1:
  - `gnt0` is high in both cycles.
  - `rvalid0` = 1 with `rdata0` = 56 on the following cycle; `rvalid1` = 0.
- `req0` and `req1` both held high doing writes for 6 cycles:
  - Grant order is 0,1,0,1,0,1.
  - Exactly one `mem_wr_en` per cycle.
- `req1` writes addr 3 data 200, then `req0` reads addr 3 on the next cycle:
  - `rvalid0` = 1 with data 200.
- `req1` asserted during INIT:
  - No grant until the first ARB cycle, then `gnt1` = 1 in that cycle.
- Sequence: write addr 2 = 74, grant a read of addr 2, assert `rst` the next cycle:
  - `rvalid0` and `rvalid1` stay 0.
  - Init reruns.
  - A read of addr 2 after `init_done` returns 0.
